// File: rtl/gpio_v2.sv
// MMIO GPIO controller: pad ownership, direction and output registers, atomic
// set/clear/toggle, synchronised input sampling and sticky edge interrupts.
module gpio_v2 #(
  parameter int unsigned NUM_CH      = 8,
  parameter int unsigned SYNC_STAGES = 2,
  parameter int unsigned ADDR_W      = 7
) (
  input  logic              soc_clk,
  input  logic              rst_n,
  input  logic              gpio_enable,
  input  logic [ADDR_W-1:0] data_addr,
  input  logic [31:0]       data_store,
  output logic [31:0]       data_fetch,
  output logic [NUM_CH-1:0] master_control,
  output logic [NUM_CH-1:0] gpio_oe,
  output logic [NUM_CH-1:0] gpio_output,
  input  logic [NUM_CH-1:0] gpio_inputs,
  output logic              gpio_irq
);

  typedef enum logic [3:0] {
    RegOwn    = 4'h0,
    RegDir    = 4'h1,
    RegOut    = 4'h2,
    RegIn     = 4'h3,
    RegSet    = 4'h4,
    RegClr    = 4'h5,
    RegTgl    = 4'h6,
    RegIrqEn  = 4'h7,
    RegRise   = 4'h8,
    RegFall   = 4'h9,
    RegStatus = 4'hA,
    RegInfo   = 4'hB
  } reg_e;

  localparam logic [2:0]  ArmCount = 3'(SYNC_STAGES + 1);
  localparam logic [31:0] InfoVal  = {16'h0, 8'(SYNC_STAGES), 8'(NUM_CH)};

  logic [NUM_CH-1:0] own_q, own_d;
  logic [NUM_CH-1:0] dir_q, dir_d;
  logic [NUM_CH-1:0] out_q, out_d;
  logic [NUM_CH-1:0] irq_en_q, irq_en_d;
  logic [NUM_CH-1:0] rise_en_q, rise_en_d;
  logic [NUM_CH-1:0] fall_en_q, fall_en_d;
  logic [NUM_CH-1:0] status_q, status_d;
  logic [NUM_CH-1:0] in_prev_q;
  logic [SYNC_STAGES-1:0][NUM_CH-1:0] sync_q;
  logic [2:0]        arm_q;

  logic              is_wr;
  logic              addr_ok;
  logic              wr_en;
  logic              rd_en;
  reg_e              reg_idx;
  logic [NUM_CH-1:0] wdata;
  logic [NUM_CH-1:0] w1c;
  logic [NUM_CH-1:0] in_sync;
  logic [NUM_CH-1:0] rise;
  logic [NUM_CH-1:0] fall;
  logic [NUM_CH-1:0] ev;
  logic              armed;
  logic              unused_store;

  assign is_wr   = data_addr[6];
  assign reg_idx = reg_e'(data_addr[5:2]);
  // Only word-aligned offsets inside the 7-bit window decode.
  assign addr_ok = (data_addr[1:0] == 2'b00) && ((data_addr >> 7) == '0);
  assign wr_en   = gpio_enable && is_wr && addr_ok;
  assign rd_en   = gpio_enable && !is_wr && addr_ok;
  assign wdata   = data_store[NUM_CH-1:0];
  assign unused_store = ^data_store;

  assign in_sync = sync_q[SYNC_STAGES-1];
  assign rise    = in_sync & ~in_prev_q;
  assign fall    = ~in_sync & in_prev_q;
  // Suppress edges until the synchroniser has flushed its reset contents.
  assign armed   = (arm_q == ArmCount);
  assign ev      = armed ? ((rise & rise_en_q) | (fall & fall_en_q)) : '0;

  always_comb begin
    own_d     = own_q;
    dir_d     = dir_q;
    out_d     = out_q;
    irq_en_d  = irq_en_q;
    rise_en_d = rise_en_q;
    fall_en_d = fall_en_q;
    w1c       = '0;
    if (wr_en) begin
      case (reg_idx)
        RegOwn:    own_d     = wdata;
        RegDir:    dir_d     = wdata;
        RegOut:    out_d     = wdata;
        RegSet:    out_d     = out_q | wdata;
        RegClr:    out_d     = out_q & ~wdata;
        RegTgl:    out_d     = out_q ^ wdata;
        RegIrqEn:  irq_en_d  = wdata;
        RegRise:   rise_en_d = wdata;
        RegFall:   fall_en_d = wdata;
        RegStatus: w1c       = wdata;
        default:   ;
      endcase
    end
    // Set after clear so a same-cycle event beats the W1C.
    status_d = (status_q & ~w1c) | ev;
  end

  always_comb begin
    data_fetch = '0;
    if (rd_en) begin
      case (reg_idx)
        RegOwn:    data_fetch = 32'(own_q);
        RegDir:    data_fetch = 32'(dir_q);
        RegOut:    data_fetch = 32'(out_q);
        RegIn:     data_fetch = 32'(in_sync);
        RegIrqEn:  data_fetch = 32'(irq_en_q);
        RegRise:   data_fetch = 32'(rise_en_q);
        RegFall:   data_fetch = 32'(fall_en_q);
        RegStatus: data_fetch = 32'(status_q);
        RegInfo:   data_fetch = InfoVal;
        default:   data_fetch = '0;
      endcase
    end
  end

  always_ff @(posedge soc_clk or negedge rst_n) begin
    if (!rst_n) begin
      own_q     <= '0;
      dir_q     <= '0;
      out_q     <= '0;
      irq_en_q  <= '0;
      rise_en_q <= '0;
      fall_en_q <= '0;
      status_q  <= '0;
      in_prev_q <= '0;
      sync_q    <= '0;
      arm_q     <= '0;
    end else begin
      own_q     <= own_d;
      dir_q     <= dir_d;
      out_q     <= out_d;
      irq_en_q  <= irq_en_d;
      rise_en_q <= rise_en_d;
      fall_en_q <= fall_en_d;
      status_q  <= status_d;
      in_prev_q <= in_sync;
      sync_q    <= {sync_q[SYNC_STAGES-2:0], gpio_inputs};
      if (!armed) begin
        arm_q <= arm_q + 3'd1;
      end
    end
  end

  assign master_control = own_q;
  assign gpio_oe        = dir_q;
  assign gpio_output    = out_q;
  assign gpio_irq       = |(status_q & irq_en_q);

endmodule

// File: tb/tb_gpio_v2.sv
// Self-checking bench for gpio_v2: table-driven MMIO vectors with a pin scoreboard,
// plus hand sequences for reset arming, edge timing, W1C races and async reset.
module tb_gpio_v2;

  logic        soc_clk;
  logic        rst_n;
  logic        gpio_enable;
  logic [6:0]  data_addr;
  logic [31:0] data_store;
  logic [31:0] data_fetch;
  logic [7:0]  master_control;
  logic [7:0]  gpio_oe;
  logic [7:0]  gpio_output;
  logic [7:0]  gpio_inputs;
  logic        gpio_irq;

  gpio_v2 #(
    .NUM_CH      (8),
    .SYNC_STAGES (2),
    .ADDR_W      (7)
  ) dut (
    .soc_clk        (soc_clk),
    .rst_n          (rst_n),
    .gpio_enable    (gpio_enable),
    .data_addr      (data_addr),
    .data_store     (data_store),
    .data_fetch     (data_fetch),
    .master_control (master_control),
    .gpio_oe        (gpio_oe),
    .gpio_output    (gpio_output),
    .gpio_inputs    (gpio_inputs),
    .gpio_irq       (gpio_irq)
  );

  initial begin
    soc_clk = 1'b0;
    forever #5 soc_clk = ~soc_clk;
  end

  typedef struct {
    logic [7:0] own;
    logic [7:0] oe;
    logic [7:0] out;
    logic       irq;
  } pins_t;

  typedef struct {
    logic [6:0]  addr;
    logic [31:0] wdata;
    logic [31:0] exp_rd;
    pins_t       pins;
  } vec_t;

  int    n_checks = 0;
  int    n_fail   = 0;
  pins_t exp_q[$];
  vec_t  vecs[19];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h, expected %h", name, act, exp);
    end
  endtask

  task automatic check_pins(input string name, input pins_t e);
    check({name, ".own"}, 32'(master_control), 32'(e.own));
    check({name, ".oe"},  32'(gpio_oe),        32'(e.oe));
    check({name, ".out"}, 32'(gpio_output),    32'(e.out));
    check({name, ".irq"}, 32'(gpio_irq),       32'(e.irq));
  endtask

  // Call at posedge+1; strobe one access, check read data, then scoreboard pins after the edge.
  task automatic bus(input string name, input logic [6:0] addr, input logic [31:0] wdata,
                     input logic [31:0] exp_rd, input pins_t exp_p);
    pins_t got;
    gpio_enable = 1'b1;
    data_addr   = addr;
    data_store  = wdata;
    #1;
    check({name, ".rd"}, data_fetch, exp_rd);
    exp_q.push_back(exp_p);
    @(posedge soc_clk);
    #1;
    gpio_enable = 1'b0;
    data_addr   = '0;
    data_store  = '0;
    got = exp_q.pop_front();
    check_pins(name, got);
  endtask

  // Side-effect-free read sampled between edges.
  task automatic read_now(input string name, input logic [6:0] addr, input logic [31:0] exp);
    gpio_enable = 1'b1;
    data_addr   = addr;
    #1;
    check(name, data_fetch, exp);
    gpio_enable = 1'b0;
    data_addr   = '0;
  endtask

  function automatic pins_t mk(input logic [7:0] own, input logic [7:0] oe,
                               input logic [7:0] out, input logic irq);
    pins_t p;
    p.own = own;
    p.oe  = oe;
    p.out = out;
    p.irq = irq;
    return p;
  endfunction

  initial begin
    vecs[0]  = '{7'h48, 32'h0000_00A5, 32'h0,        mk(8'h00, 8'h00, 8'hA5, 1'b0)};
    vecs[1]  = '{7'h44, 32'h0000_00FF, 32'h0,        mk(8'h00, 8'hFF, 8'hA5, 1'b0)};
    vecs[2]  = '{7'h08, 32'h0,         32'h0000_00A5, mk(8'h00, 8'hFF, 8'hA5, 1'b0)};
    vecs[3]  = '{7'h2C, 32'h0,         32'h0000_0208, mk(8'h00, 8'hFF, 8'hA5, 1'b0)};
    vecs[4]  = '{7'h40, 32'h0000_003C, 32'h0,        mk(8'h3C, 8'hFF, 8'hA5, 1'b0)};
    vecs[5]  = '{7'h00, 32'h0,         32'h0000_003C, mk(8'h3C, 8'hFF, 8'hA5, 1'b0)};
    vecs[6]  = '{7'h50, 32'h0000_000A, 32'h0,        mk(8'h3C, 8'hFF, 8'hAF, 1'b0)};
    vecs[7]  = '{7'h54, 32'h0000_000F, 32'h0,        mk(8'h3C, 8'hFF, 8'hA0, 1'b0)};
    vecs[8]  = '{7'h58, 32'h0000_00FF, 32'h0,        mk(8'h3C, 8'hFF, 8'h5F, 1'b0)};
    vecs[9]  = '{7'h08, 32'h0,         32'h0000_005F, mk(8'h3C, 8'hFF, 8'h5F, 1'b0)};
    vecs[10] = '{7'h10, 32'h0,         32'h0,        mk(8'h3C, 8'hFF, 8'h5F, 1'b0)};
    vecs[11] = '{7'h4C, 32'h0000_00FF, 32'h0,        mk(8'h3C, 8'hFF, 8'h5F, 1'b0)};
    vecs[12] = '{7'h0C, 32'h0,         32'h0,        mk(8'h3C, 8'hFF, 8'h5F, 1'b0)};
    vecs[13] = '{7'h7C, 32'h0000_00FF, 32'h0,        mk(8'h3C, 8'hFF, 8'h5F, 1'b0)};
    vecs[14] = '{7'h3C, 32'h0,         32'h0,        mk(8'h3C, 8'hFF, 8'h5F, 1'b0)};
    vecs[15] = '{7'h48, 32'hFFFF_FF00, 32'h0,        mk(8'h3C, 8'hFF, 8'h00, 1'b0)};
    vecs[16] = '{7'h08, 32'h0,         32'h0,        mk(8'h3C, 8'hFF, 8'h00, 1'b0)};
    vecs[17] = '{7'h1C, 32'h0,         32'h0,        mk(8'h3C, 8'hFF, 8'h00, 1'b0)};
    vecs[18] = '{7'h20, 32'h0,         32'h0,        mk(8'h3C, 8'hFF, 8'h00, 1'b0)};

    rst_n       = 1'b0;
    gpio_enable = 1'b0;
    data_addr   = '0;
    data_store  = '0;
    gpio_inputs = 8'hFF;

    // Reset with inputs high: every output quiet.
    repeat (3) @(posedge soc_clk);
    #1;
    check_pins("reset", mk(8'h00, 8'h00, 8'h00, 1'b0));
    check("reset.fetch", data_fetch, 32'h0);
    read_now("reset.status_rd", 7'h28, 32'h0);

    // Enable rise detection in the first cycle: the reset-to-one transition must not be seen.
    rst_n = 1'b1;
    bus("arm.rise_en", 7'h60, 32'h0000_00FF, 32'h0, mk(8'h00, 8'h00, 8'h00, 1'b0));
    repeat (9) @(posedge soc_clk);
    #1;
    read_now("arm.status", 7'h28, 32'h0);
    read_now("arm.in", 7'h0C, 32'h0000_00FF);
    check("arm.irq", 32'(gpio_irq), 32'h0);
    gpio_inputs = 8'h00;
    bus("arm.rise_off", 7'h60, 32'h0, 32'h0, mk(8'h00, 8'h00, 8'h00, 1'b0));

    for (int i = 0; i < 19; i++) begin
      bus($sformatf("vec%0d", i), vecs[i].addr, vecs[i].wdata, vecs[i].exp_rd, vecs[i].pins);
    end

    // Rising edge on bit 3: visible in IN after two edges, latched in status after three.
    bus("t4.rise", 7'h60, 32'h08, 32'h0, mk(8'h3C, 8'hFF, 8'h00, 1'b0));
    bus("t4.en",   7'h5C, 32'h08, 32'h0, mk(8'h3C, 8'hFF, 8'h00, 1'b0));
    gpio_inputs = 8'h08;
    @(posedge soc_clk);
    #1;
    read_now("t4.in_e1", 7'h0C, 32'h0);
    @(posedge soc_clk);
    #1;
    read_now("t4.in_e2", 7'h0C, 32'h08);
    read_now("t4.status_e2", 7'h28, 32'h0);
    check("t4.irq_e2", 32'(gpio_irq), 32'h0);
    @(posedge soc_clk);
    #1;
    read_now("t4.status_e3", 7'h28, 32'h08);
    check("t4.irq_e3", 32'(gpio_irq), 32'h1);

    // W1C clears; then a falling edge landing in the W1C cycle keeps the bit set.
    bus("t5.w1c", 7'h68, 32'h08, 32'h0, mk(8'h3C, 8'hFF, 8'h00, 1'b0));
    read_now("t5.status_clr", 7'h28, 32'h0);
    bus("t5.fall", 7'h64, 32'h08, 32'h0, mk(8'h3C, 8'hFF, 8'h00, 1'b0));
    gpio_inputs = 8'h00;
    repeat (2) @(posedge soc_clk);
    #1;
    read_now("t5.pre_race", 7'h28, 32'h0);
    bus("t5.race", 7'h68, 32'h08, 32'h0, mk(8'h3C, 8'hFF, 8'h00, 1'b1));
    read_now("t5.status_race", 7'h28, 32'h08);

    // W1C of an unset bit is harmless; status latches even when masked.
    bus("t6.w1c_other", 7'h68, 32'h80, 32'h0, mk(8'h3C, 8'hFF, 8'h00, 1'b1));
    read_now("t6.status_kept", 7'h28, 32'h08);
    bus("t6.w1c", 7'h68, 32'h08, 32'h0, mk(8'h3C, 8'hFF, 8'h00, 1'b0));
    bus("t6.en_off", 7'h5C, 32'h0, 32'h0, mk(8'h3C, 8'hFF, 8'h00, 1'b0));
    gpio_inputs = 8'h08;
    repeat (3) @(posedge soc_clk);
    #1;
    read_now("t6.status_masked", 7'h28, 32'h08);
    check("t6.irq_masked", 32'(gpio_irq), 32'h0);

    // Deselected bus reads zero even with a live register address.
    data_addr = 7'h28;
    #1;
    check("idle.fetch", data_fetch, 32'h0);
    data_addr = '0;

    // Mid-cycle reset clears state without waiting for a clock edge.
    rst_n = 1'b0;
    #1;
    check_pins("async_rst", mk(8'h00, 8'h00, 8'h00, 1'b0));
    read_now("async_rst.status", 7'h28, 32'h0);
    rst_n = 1'b1;

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
